// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the serial binary-to-BCD conversion controller.
// Default operand width and digit count, plus the FSM state encodings.
package bcd_ctrl_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DIGITS = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      SHIFT   = 3'd2,
      CAPTURE = 3'd3,
      HOLD    = 3'd4
   } state_t;

endpackage

// File: rtl/bcd_dd_serial.sv
// Serial double-dabble BCD converter: one input bit per shift, MSB first, add-3 before each shift.
// Latency: result valid the cycle after the last shift; no backpressure, strobes are always honoured.
module bcd_dd_serial #(
   parameter int DIGITS = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  shift_i,
   input  logic                  bit_i,
   output logic [4*DIGITS-1:0]   bcd_o
);

   logic [4*DIGITS-1:0] adj;

   always_comb begin
      adj = bcd_o;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_o[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_o[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bcd_o <= '0;
      end else if (clr_i) begin
         bcd_o <= '0;
      end else if (shift_i) begin
         bcd_o <= {adj[4*DIGITS-2:0], bit_i};
      end
   end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Sequences one operand through an external serial BCD converter and holds the captured result.
// Latency DATA_W+2 edges accept->out_valid_o; result held until out_ready_i, no input queuing.
module bcd_conv_ctrl
   import bcd_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_W-1:0]     in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic                  conv_clr_o,
   output logic                  conv_shift_o,
   output logic                  conv_bit_o,
   input  logic [4*DIGITS-1:0]   conv_bcd_i,
   output logic [4*DIGITS-1:0]   out_bcd_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  busy_o,
   output logic [15:0]           conv_cnt_o
);

   localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t              state_q;
   state_t              state_d;
   logic [DATA_W-1:0]   shreg_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic                accept;

   assign accept = in_valid_i & in_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid_i) state_d = CLEAR;
         CLEAR:   state_d = SHIFT;
         SHIFT:   if (bit_cnt_q == LAST_BIT) state_d = CAPTURE;
         CAPTURE: state_d = HOLD;
         HOLD:    if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o   = (state_q == IDLE);
      busy_o       = (state_q != IDLE);
      conv_clr_o   = (state_q == CLEAR);
      conv_shift_o = (state_q == SHIFT);
      // Gated so the converter never sees a stale MSB outside SHIFT.
      conv_bit_o   = (state_q == SHIFT) ? shreg_q[DATA_W-1] : 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         if (accept) begin
            shreg_q <= in_data_i;
         end else if (state_q == SHIFT) begin
            shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
         end
         if (state_q == SHIFT && bit_cnt_q != LAST_BIT) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
         end else begin
            bit_cnt_q <= '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_bcd_o   <= '0;
         out_valid_o <= 1'b0;
         conv_cnt_o  <= '0;
      end else if (state_q == CAPTURE) begin
         out_bcd_o   <= conv_bcd_i;
         out_valid_o <= 1'b1;
         conv_cnt_o  <= conv_cnt_o + 16'd1;
      end else if (state_q == HOLD && out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Directed/self-checking bench: controller plus serial double-dabble converter as the datapath.
// Checks latency, strobes, serial bits, results, hold behaviour, reset abort and counter wrap.
`timescale 1ns/1ps
module tb_bcd_conv_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        conv_clr;
   logic        conv_shift;
   logic        conv_bit;
   logic [11:0] conv_bcd;
   logic [11:0] out_bcd;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy;
   logic [15:0] conv_cnt;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_cnt  = '0;
   longint      prev_acc = -1;
   longint      acc_t    = 0;

   // Per operand: IDLE accept cycle + CLEAR + DATA_W SHIFT + CAPTURE + HOLD.
   localparam int ACC_SPACING = 12;

   always #5 clk = ~clk;

   bcd_conv_ctrl #(.DATA_W(8), .DIGITS(3)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_data_i    (in_data),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .conv_clr_o   (conv_clr),
      .conv_shift_o (conv_shift),
      .conv_bit_o   (conv_bit),
      .conv_bcd_i   (conv_bcd),
      .out_bcd_o    (out_bcd),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .busy_o       (busy),
      .conv_cnt_o   (conv_cnt)
   );

   bcd_dd_serial #(.DIGITS(3)) u_conv (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (conv_clr),
      .shift_i (conv_shift),
      .bit_i   (conv_bit),
      .bcd_o   (conv_bcd)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check_reset_outs(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),   32'd1);
      check({tag, "_busy"},      32'(busy),       32'd0);
      check({tag, "_clr"},       32'(conv_clr),   32'd0);
      check({tag, "_shift"},     32'(conv_shift), 32'd0);
      check({tag, "_bit"},       32'(conv_bit),   32'd0);
      check({tag, "_out_valid"}, 32'(out_valid),  32'd0);
      check({tag, "_out_bcd"},   32'(out_bcd),    32'd0);
      check({tag, "_cnt"},       32'(conv_cnt),   32'd0);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
   endtask

   // Accepts one operand and follows it to out_valid_o; returns #1 after the rising edge.
   task automatic do_op(input string tag, input logic [7:0] d, input logic [11:0] exp);
      int         n = 0;
      int         n_clr = 0;
      int         n_shift = 0;
      int         bad_bit = 0;
      logic [7:0] bits = '0;
      wait_ready(tag);
      in_data  = d;
      in_valid = 1'b1;
      @(posedge clk);
      acc_t = $time;
      #1;
      in_valid = 1'b0;
      in_data  = ~d;
      while (!out_valid && n < 40) begin
         if (conv_clr) n_clr++;
         if (conv_shift) begin
            n_shift++;
            bits = {bits[6:0], conv_bit};
         end else if (conv_bit) begin
            bad_bit++;
         end
         @(posedge clk);
         #1;
         n++;
      end
      exp_cnt = exp_cnt + 16'd1;
      check({tag, "_latency"},  32'(n),        32'd10);
      check({tag, "_n_clr"},    32'(n_clr),    32'd1);
      check({tag, "_n_shift"},  32'(n_shift),  32'd8);
      check({tag, "_bits"},     32'(bits),     32'(d));
      check({tag, "_bit_idle"}, 32'(bad_bit),  32'd0);
      check({tag, "_bcd"},      32'(out_bcd),  32'(exp));
      check({tag, "_busy"},     32'(busy),     32'd1);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_cnt"},      32'(conv_cnt), 32'(exp_cnt));
   endtask

   task automatic finish_hold(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
   endtask

   logic [7:0]  dir_in  [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128};
   logic [11:0] dir_exp [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b1;
      #2;
      check_reset_outs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Full-scale operand with downstream always ready.
      out_ready = 1'b1;
      do_op("op255", 8'd255, 12'h255);
      finish_hold("op255");

      for (int i = 0; i < 6; i++) begin
         do_op($sformatf("dir%0d", i), dir_in[i], dir_exp[i]);
         finish_hold($sformatf("dir%0d", i));
      end

      // Downstream stalls: result must hold, new operands must be ignored.
      out_ready = 1'b0;
      do_op("hold", 8'd200, 12'h200);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'd55;
         check("hold_bcd",      32'(out_bcd),   32'h200);
         check("hold_valid",    32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready),  32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      finish_hold("hold");
      @(negedge clk);
      check("hold_no_queue_busy", 32'(busy),     32'd0);
      check("hold_cnt",           32'(conv_cnt), 32'(exp_cnt));

      // Reset in the 4th SHIFT cycle aborts the conversion.
      wait_ready("rst_mid");
      in_data  = 8'd200;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("rst_mid_in_shift", 32'(conv_shift), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outs("rst_mid");
      exp_cnt = '0;
      @(negedge clk);
      rst = 1'b0;
      do_op("after_rst", 8'd37, 12'h037);
      finish_hold("after_rst");

      // Back-to-back random operands from a fresh reset.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt  = '0;
      prev_acc = -1;
      for (int i = 0; i < 50; i++) begin
         logic [7:0] v;
         v = 8'($urandom_range(0, 255));
         do_op($sformatf("rnd%0d", i), v, to_bcd(int'(v)));
         if (prev_acc >= 0) check("rnd_spacing", 32'((acc_t - prev_acc) / 10), 32'(ACC_SPACING));
         prev_acc = acc_t;
         finish_hold("rnd");
      end
      check("rnd_cnt_total", 32'(conv_cnt), 32'd50);

      // Counter wraps from 0xFFFF.
      @(negedge clk);
      force dut.conv_cnt_o = 16'hFFFF;
      #1;
      release dut.conv_cnt_o;
      exp_cnt = 16'hFFFF;
      do_op("wrap", 8'd1, 12'h001);
      finish_hold("wrap");
      check("wrap_cnt_zero", 32'(conv_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
